// File: rtl/ldpcdec_syn_if.sv
// ldpcdec_syn_if: codeword stream, shift-table lookup and result signals of the syndrome checker
interface ldpcdec_syn_if;
    logic        start;
    logic [3:0]  mode;
    logic        vld;
    logic        in_rdy;
    logic [26:0] data_in;
    logic [8:0]  tbl_addr;
    logic [7:0]  sh1, sh2, sh3, sh4, sh5, sh6, sh7, sh8, sh9, sh10, sh11, sh12;
    logic        done;
    logic        pass;
    logic [3:0]  err_cnt;
    modport master (
        output start, mode, vld, data_in,
        output sh1, sh2, sh3, sh4, sh5, sh6, sh7, sh8, sh9, sh10, sh11, sh12,
        input  in_rdy, tbl_addr, done, pass, err_cnt
    );
    modport slave (
        input  start, mode, vld, data_in,
        input  sh1, sh2, sh3, sh4, sh5, sh6, sh7, sh8, sh9, sh10, sh11, sh12,
        output in_rdy, tbl_addr, done, pass, err_cnt
    );
endinterface

// File: rtl/ldpcdec_syn.sv
// ldpcdec_syn: hard-decision LDPC syndrome checker accumulating rotated column blocks per row block
module ldpcdec_syn #(
    parameter int NCOL = 24,
    parameter int NROW = 12
) (
    input logic          clk,
    input logic          rst,
    ldpcdec_syn_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RECV, FLUSH, DONE} state_t;
    state_t                 r_state, w_next;
    logic [3:0]             r_mode;
    logic [4:0]             r_col;
    logic [1:0]             r_wcnt;
    logic [80:0]            r_asm, r_blk, w_blk;
    logic                   r_acc, r_valid;
    logic [80:0]            r_x [NROW];
    logic [NROW-1:0][7:0]   w_sh;
    logic [1:0]             w_wl;
    logic [3:0]             w_nact, w_err;
    logic                   w_xfer, w_last;

    function automatic logic [80:0] rot(input logic [80:0] d, input logic [7:0] s, input logic [1:0] l);
        logic [53:0]  d27;
        logic [107:0] d54;
        logic [161:0] d81;
        d27 = {d[26:0], d[26:0]} >> (s % 8'd27);
        d54 = {d[53:0], d[53:0]} >> (s % 8'd54);
        d81 = {d, d} >> (s % 8'd81);
        return l == 2'd0 ? {54'd0, d27[26:0]} : l == 2'd1 ? {27'd0, d54[53:0]} : d81[80:0];
    endfunction

    assign w_sh   = {bus.sh12, bus.sh11, bus.sh10, bus.sh9, bus.sh8, bus.sh7,
                     bus.sh6, bus.sh5, bus.sh4, bus.sh3, bus.sh2, bus.sh1};
    assign w_wl   = r_mode[3:2] == 2'd0 ? 2'd0 : r_mode[3:2] == 2'd1 ? 2'd1 : 2'd2;
    assign w_nact = r_mode[1:0] == 2'd0 ? 4'd12 : r_mode[1:0] == 2'd1 ? 4'd8 :
                    r_mode[1:0] == 2'd2 ? 4'd6 : 4'd4;
    assign w_xfer = bus.vld && r_state == RECV;
    assign w_last = w_xfer && r_wcnt == w_wl;
    // Slots above the current word are zero, so short lifting sizes never carry stale upper bits
    assign w_blk  = r_wcnt == 2'd0 ? {54'd0, bus.data_in} :
                    r_wcnt == 2'd1 ? {27'd0, bus.data_in, r_asm[26:0]} :
                                     {bus.data_in, r_asm[53:0]};

    assign bus.in_rdy   = r_state == RECV;
    assign bus.done     = r_state == DONE;
    assign bus.tbl_addr = {r_mode, r_col};
    assign bus.pass     = r_valid && w_err == 4'd0;
    assign bus.err_cnt  = r_valid ? w_err : 4'd0;

    always_comb begin
        w_err = '0;
        for (int r = 0; r < NROW; r++)
            w_err = w_err + {3'd0, (4'(r) < w_nact) && (|r_x[r])};
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.start ? RECV : IDLE;
            RECV:    w_next = (w_last && r_col == 5'(NCOL - 1)) ? FLUSH : RECV;
            FLUSH:   w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_mode  <= '0;
            r_col   <= '0;
            r_wcnt  <= '0;
            r_asm   <= '0;
            r_blk   <= '0;
            r_acc   <= 1'b0;
            r_valid <= 1'b0;
            for (int r = 0; r < NROW; r++) r_x[r] <= '0;
        end else begin
            r_state <= w_next;
            r_acc   <= w_last;
            if (r_state == IDLE && bus.start) begin
                r_mode  <= bus.mode;
                r_col   <= '0;
                r_wcnt  <= '0;
                r_valid <= 1'b0;
                for (int r = 0; r < NROW; r++) r_x[r] <= '0;
            end
            if (r_state == FLUSH) r_valid <= 1'b1;
            if (w_xfer) begin
                r_asm  <= w_blk;
                r_wcnt <= w_last ? 2'd0 : r_wcnt + 2'd1;
                if (w_last) begin
                    r_blk <= w_blk;
                    r_col <= r_col + 5'd1;
                end
            end
            // Shifts for the block captured last cycle arrive now from the registered table
            if (r_acc)
                for (int r = 0; r < NROW; r++)
                    if (w_sh[r] != 8'd255) r_x[r] <= r_x[r] ^ rot(r_blk, w_sh[r], r_mode[3:2]);
        end
    end
endmodule

// File: tb/tb_ldpcdec_syn.sv
// tb_ldpcdec_syn: directed codewords with a queued scoreboard checked whenever done pulses
module tb_ldpcdec_syn;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   test_id = 0;
    logic [26:0] wq[$];
    logic [3:0]  cur_mode = '0;
    logic [7:0]  shtab1 [32];
    logic [7:0]  shtab5 [32];
    typedef struct {logic p; logic [3:0] e; int c; int id;} exp_t;
    exp_t sbq[$];
    exp_t mx;
    logic tab_ok;

    ldpcdec_syn_if bus();
    ldpcdec_syn dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered shift table; a wrong address yields a shift that breaks the expected syndromes
    assign tab_ok = bus.tbl_addr[8:5] == cur_mode && bus.tbl_addr[4:0] < 5'd24;
    always @(posedge clk) begin
        bus.sh1 <= tab_ok ? shtab1[bus.tbl_addr[4:0]] : 8'd3;
        bus.sh5 <= tab_ok ? shtab5[bus.tbl_addr[4:0]] : 8'd3;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (bus.done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                mx = sbq.pop_front();
                check($sformatf("pass_t%0d", mx.id), {31'd0, bus.pass}, {31'd0, mx.p});
                check($sformatf("err_cnt_t%0d", mx.id), {28'd0, bus.err_cnt}, {28'd0, mx.e});
                check($sformatf("done_cycle_t%0d", mx.id), cyc, mx.c);
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic tabs(input logic [7:0] a);
        for (int i = 0; i < 32; i++) begin
            shtab1[i] = a;
            shtab5[i] = 8'd255;
        end
    endtask

    task automatic fill(input int n, input logic [26:0] v);
        wq.delete();
        repeat (n) wq.push_back(v);
    endtask

    task automatic flip(input int w, input int b);
        logic [26:0] t;
        t = wq[w];
        t[b] = ~t[b];
        wq[w] = t;
    endtask

    task automatic begin_cw(input logic [3:0] m);
        cur_mode = m;
        bus.mode = m;
        bus.start = 1'b1;
        step;
        bus.start = 1'b0;
    endtask

    task automatic send(input int lo, input int hi, input bit gaps, output int first, output int last);
        first = 0;
        last = 0;
        for (int i = lo; i <= hi; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.vld = 1'b0;
                step;
            end
            bus.vld = 1'b1;
            bus.data_in = wq[i];
            for (int t = 0; !bus.in_rdy; t++) begin
                if (t > 20) begin
                    checks++;
                    errors++;
                    $display("FAIL in_rdy_timeout word %0d", i);
                    bus.vld = 1'b0;
                    return;
                end
                step;
            end
            step;
            if (i == lo) first = cyc - 1;
            last = cyc - 1;
        end
        bus.vld = 1'b0;
    endtask

    task automatic drain;
        for (int t = 0; t < 10 && sbq.size() > 0; t++) step;
        if (sbq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout pending %0d", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic run(input logic [3:0] m, input bit gaps, input logic p, input logic [3:0] e, input bit b2b);
        int f, l;
        test_id++;
        begin_cw(m);
        send(0, wq.size() - 1, gaps, f, l);
        if (b2b) check("back_to_back_cycles", l - f, wq.size() - 1);
        sbq.push_back('{p, e, l + 2, test_id});
        drain;
    endtask

    initial begin
        int f, l;
        bus.start = 1'b0;
        bus.mode = '0;
        bus.vld = 1'b0;
        bus.data_in = '0;
        {bus.sh2, bus.sh3, bus.sh4} = {3{8'd255}};
        {bus.sh6, bus.sh7, bus.sh8, bus.sh9, bus.sh10, bus.sh11, bus.sh12} = {7{8'd255}};
        tabs(8'd0);
        repeat (3) step;
        rst = 1'b0;
        check("reset_in_rdy", {31'd0, bus.in_rdy}, 0);
        check("reset_done", {31'd0, bus.done}, 0);
        check("reset_pass", {31'd0, bus.pass}, 0);
        check("reset_err_cnt", {28'd0, bus.err_cnt}, 0);
        check("reset_tbl_addr", {23'd0, bus.tbl_addr}, 0);
        fill(24, '0);
        run(4'b0000, 0, 1'b1, 4'd0, 1);
        flip(5, 3);
        run(4'b0000, 0, 1'b0, 4'd1, 0);
        flip(9, 3);
        run(4'b0000, 0, 1'b1, 4'd0, 0);
        tabs(8'd1);
        for (int i = 0; i < 32; i++) shtab5[i] = 8'd0;
        fill(72, '0);
        flip(2, 0);
        run(4'b1011, 0, 1'b0, 4'd1, 0);
        run(4'b1001, 0, 1'b0, 4'd2, 0);
        tabs(8'd0);
        fill(48, 27'h7FFFFFF);
        run(4'b0100, 1, 1'b1, 4'd0, 0);
        shtab1[0] = 8'd3;
        shtab1[1] = 8'd27;
        fill(24, '0);
        flip(0, 5);
        flip(1, 2);
        run(4'b0000, 1, 1'b1, 4'd0, 0);
        shtab1[1] = 8'd28;
        run(4'b0000, 0, 1'b0, 4'd1, 0);
        tabs(8'd0);
        shtab1[0] = 8'd1;
        fill(48, '0);
        flip(0, 0);
        flip(3, 26);
        run(4'b0100, 0, 1'b1, 4'd0, 0);
        tabs(8'd0);
        fill(24, '0);
        flip(4, 7);
        begin_cw(4'b0000);
        send(0, 9, 0, f, l);
        rst = 1'b1;
        step;
        rst = 1'b0;
        check("rst_in_rdy", {31'd0, bus.in_rdy}, 0);
        check("rst_pass", {31'd0, bus.pass}, 0);
        check("rst_err_cnt", {28'd0, bus.err_cnt}, 0);
        repeat (6) step;
        fill(24, '0);
        run(4'b0000, 0, 1'b1, 4'd0, 1);
        flip(5, 3);
        test_id++;
        begin_cw(4'b0000);
        send(0, 7, 0, f, l);
        bus.mode = 4'b1011;
        bus.start = 1'b1;
        step;
        bus.start = 1'b0;
        check("recv_start_tbl_addr", {23'd0, bus.tbl_addr}, 32'd8);
        send(8, 23, 0, f, l);
        sbq.push_back('{1'b0, 4'd1, l + 2, test_id});
        bus.start = 1'b1;
        step;
        step;
        bus.start = 1'b0;
        bus.mode = 4'b0000;
        drain;
        step;
        check("start_in_done_ignored", {31'd0, bus.in_rdy}, 0);
        check("held_err_cnt", {28'd0, bus.err_cnt}, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
